// File: rtl/fifo_srw.sv
// First-word-fall-through FIFO wrapped around a simultaneous read/write RAM.
// The FIFO drives the RAM write port from the push stream and the read port to the pop stream.

module ram_SRW #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  ce_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned WORDS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  // Registered write, zero-latency read.
  always_ff @(posedge clk) begin
    if (ce_i && we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

module fifo_srw #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned PTR_WIDTH    = $clog2(DEPTH),
  parameter int unsigned AFULL_THRESH = DEPTH - 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [DATA_WIDTH-1:0]        in_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [DATA_WIDTH-1:0]        out_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         almost_full_o
);

  localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1);

  logic [PTR_WIDTH-1:0] wptr;
  logic [PTR_WIDTH-1:0] rptr;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 push;
  logic                 pop;

  // reset_n is active-high despite its name; it also blocks both handshakes.
  always_comb begin
    full_o        = (cnt == CNT_WIDTH'(DEPTH));
    empty_o       = (cnt == '0);
    almost_full_o = (cnt >= CNT_WIDTH'(AFULL_THRESH));
    in_ready_o    = ~full_o & ~reset_n;
    out_valid_o   = ~empty_o & ~reset_n;
    push          = in_valid_i & in_ready_o;
    pop           = out_valid_o & out_ready_i;
  end

  assign count_o = cnt;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_WIDTH'(1);
      if (pop)  rptr <= rptr + PTR_WIDTH'(1);
      if (push && !pop)      cnt <= cnt + CNT_WIDTH'(1);
      else if (pop && !push) cnt <= cnt - CNT_WIDTH'(1);
    end
  end

  // Push and pop together only when 0 < cnt < DEPTH, so the two addresses never collide.
  ram_SRW #(
    .ADDR_WIDTH (PTR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .ce_i    (1'b1),
    .we_i    (push),
    .waddr_i (wptr),
    .wdata_i (in_data_i),
    .raddr_i (rptr),
    .rdata_o (out_data_o)
  );

  logic                  stall_q;
  logic [DATA_WIDTH-1:0] stall_data_q;

  always_ff @(posedge clk) begin
    stall_q      <= in_valid_i & ~in_ready_o & ~reset_n;
    stall_data_q <= in_data_i;
  end

  // Occupancy and producer-protocol invariants.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      assert (cnt <= CNT_WIDTH'(DEPTH));
      if (cnt == CNT_WIDTH'(DEPTH)) assert (wptr == rptr);
      else                          assert (PTR_WIDTH'(cnt) == PTR_WIDTH'(wptr - rptr));
      if (stall_q && in_valid_i)    assert (in_data_i == stall_data_q);
    end
  end

endmodule

// File: tb/tb_fifo_srw.sv
// Directed and randomized bench for fifo_srw, checked against a queue model of the FIFO.

module tb_fifo_srw;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = 14;

  logic        clk;
  logic        reset_n;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] in_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] out_data_o;
  logic [4:0]  count_o;
  logic        full_o;
  logic        empty_o;
  logic        almost_full_o;

  fifo_srw dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_data_i     (in_data_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_data_o    (out_data_o),
    .count_o       (count_o),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .almost_full_o (almost_full_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          nerr;
  int          nchk;
  logic [15:0] q[$];
  logic        last_push;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every observable output against the model before the edge.
  task automatic check_state(input string tag, input logic r);
    int n;
    n = q.size();
    chk({tag, ".count"},  32'(count_o),       32'(n));
    chk({tag, ".empty"},  32'(empty_o),       32'(n == 0));
    chk({tag, ".full"},   32'(full_o),        32'(n == DEPTH));
    chk({tag, ".afull"},  32'(almost_full_o), 32'(n >= AF));
    chk({tag, ".ready"},  32'(in_ready_o),    32'(!r && n < DEPTH));
    chk({tag, ".valid"},  32'(out_valid_o),   32'(!r && n > 0));
    if (!r && n > 0) chk({tag, ".data"}, 32'(out_data_o), 32'(q[0]));
  endtask

  task automatic cycle(input string tag, input logic r, input logic iv,
                       input logic [15:0] d, input logic ordy);
    logic do_push;
    logic do_pop;
    reset_n     = r;
    in_valid_i  = iv;
    in_data_i   = d;
    out_ready_i = ordy;
    #1;
    check_state(tag, r);
    do_push = iv && !r && (q.size() < DEPTH);
    do_pop  = ordy && !r && (q.size() > 0);
    @(posedge clk);
    if (r) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(d);
    end
    last_push = do_push;
    #1;
  endtask

  initial begin
    logic        pv;
    logic [15:0] pd;
    logic        r;
    logic        iv;
    logic        ordy;
    logic [15:0] d;
    nerr = 0;
    nchk = 0;
    last_push = 1'b0;
    reset_n = 1'b1;
    in_valid_i = 1'b0;
    in_data_i = '0;
    out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    cycle("rst_hold", 1'b1, 1'b1, 16'h1234, 1'b1);
    repeat (3) cycle("idle", 1'b0, 1'b0, 16'h0, 1'b0);

    // Single word: one-cycle latency, then pop.
    cycle("push1", 1'b0, 1'b1, 16'h1111, 1'b0);
    cycle("head1", 1'b0, 1'b0, 16'h0, 1'b1);
    cycle("empty1", 1'b0, 1'b0, 16'h0, 1'b0);

    // Fill to full, hold a 17th word, then pop-only at full followed by push+pop.
    for (int i = 0; i < 16; i++) cycle("fill", 1'b0, 1'b1, 16'(i), 1'b0);
    repeat (3) cycle("full_hold", 1'b0, 1'b1, 16'hDEAD, 1'b0);
    cycle("full_pop", 1'b0, 1'b1, 16'hDEAD, 1'b1);
    chk("full_pop.no_push", 32'(last_push), 32'(0));
    cycle("pushpop15", 1'b0, 1'b1, 16'hDEAD, 1'b1);
    chk("pushpop15.push", 32'(last_push), 32'(1));
    for (int i = 0; i < 15; i++) cycle("drain", 1'b0, 1'b0, 16'h0, 1'b1);
    cycle("drained", 1'b0, 1'b0, 16'h0, 1'b0);

    // Pointer wrap.
    for (int i = 0; i < 12; i++) cycle("wrap_fill", 1'b0, 1'b1, 16'(16'h0B00 + i), 1'b0);
    for (int i = 0; i < 12; i++) cycle("wrap_pop", 1'b0, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 8; i++)  cycle("wrap_push", 1'b0, 1'b1, 16'(16'h00A0 + i), 1'b0);
    for (int i = 0; i < 8; i++)  cycle("wrap_drain", 1'b0, 1'b0, 16'h0, 1'b1);
    cycle("wrap_done", 1'b0, 1'b0, 16'h0, 1'b0);

    // Steady flow at occupancy 4.
    for (int i = 0; i < 4; i++)  cycle("ss_fill", 1'b0, 1'b1, 16'(i), 1'b0);
    for (int i = 0; i < 50; i++) cycle("steady", 1'b0, 1'b1, 16'(16'h0100 + i), 1'b1);

    // Mid-run reset with 5 stored words; push and pop in the reset cycle are ignored.
    for (int i = 0; i < 4; i++) cycle("ss_drain", 1'b0, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b0, 1'b1, 16'(16'h0C00 + i), 1'b0);
    cycle("mid_rst", 1'b1, 1'b1, 16'h5555, 1'b1);
    cycle("post_rst", 1'b0, 1'b0, 16'h0, 1'b0);

    // Randomized traffic with rare resets; a stalled word stays put until accepted.
    pv = 1'b0;
    pd = '0;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 79) == 0);
      if (pv) begin
        iv = 1'b1;
        d  = pd;
      end else begin
        iv = ($urandom_range(0, 3) != 0);
        d  = 16'($urandom);
      end
      case ((i / 100) % 3)
        0:       ordy = ($urandom_range(0, 3) == 0);
        1:       ordy = ($urandom_range(0, 3) != 0);
        default: ordy = ($urandom_range(0, 1) == 0);
      endcase
      cycle("rand", r, iv, d, ordy);
      pv = iv && !last_push && !r;
      pd = d;
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
